// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner: synchronises and debounces the vending machine buttons and drink
// switches, holds each button press as a pending strobe until the controller's next tick,
// and encodes the drink selection.
// Optional build macro: DRINK_ONEHOT_EN -- drink selection is valid only for exactly one
// switch on; otherwise the lowest-index switch wins.
module coin_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic       purchase_raw,
    input  logic       nickel_raw,
    input  logic       dime_raw,
    input  logic       quarter_raw,
    input  logic [3:0] sw_raw,
    output logic       purchase_o,
    output logic       nickel_o,
    output logic       dime_o,
    output logic       quarter_o,
    output logic [7:0] coin_value,
    output logic [1:0] drink_sel,
    output logic       drink_valid,
    output logic       coin_overrun
);

    localparam int unsigned NumIn = 8;
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Input vector layout: [0] purchase, [1] nickel, [2] dime, [3] quarter, [7:4] switches
    logic [NumIn-1:0] raw;
    assign raw = {sw_raw, quarter_raw, dime_raw, nickel_raw, purchase_raw};

    logic [NumIn-1:0] sync1_q, sync2_q;
    logic [NumIn-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [NumIn];
    logic [CNT_W-1:0] cnt_d [NumIn];
    logic [NumIn-1:0] rise;

    // Coin pending flags: [0] nickel, [1] dime, [2] quarter
    logic [2:0] coin_pend_q, coin_pend_d;
    logic       purchase_pend_q, purchase_pend_d;
    logic       coin_overrun_q, coin_overrun_d;
    logic [1:0] drink_sel_q, drink_sel_d;
    logic       drink_valid_q, drink_valid_d;

    logic [2:0] coin_edge;
    logic       coin_held;

    // Debounce: count consecutive cycles of disagreement, accept the new level at the limit
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NumIn; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        rise = stable_d & ~stable_q;
    end

    // Pending strobes: a tick consumes what was pending, a same-cycle new edge survives it
    always_comb begin
        purchase_pend_d = (purchase_pend_q & ~tick) | rise[0];
        coin_edge       = rise[3:1];
        coin_held       = (coin_pend_q != 3'd0) && !tick;
        coin_pend_d     = tick ? 3'd0 : coin_pend_q;
        coin_overrun_d  = coin_overrun_q;
        if (coin_edge != 3'd0) begin
            if (coin_held) begin
                // Previous coin not yet consumed: the new one is lost
                coin_overrun_d = 1'b1;
            end else begin
                if (coin_edge[2]) begin
                    coin_pend_d = 3'b100;
                end else if (coin_edge[1]) begin
                    coin_pend_d = 3'b010;
                end else begin
                    coin_pend_d = 3'b001;
                end
                // More than one coin edge at once: the lower-priority ones are lost
                if ((coin_edge & (coin_edge - 3'd1)) != 3'd0) begin
                    coin_overrun_d = 1'b1;
                end
            end
        end
    end

    // Drink encoding from the stable switch vector
    always_comb begin
        drink_sel_d   = 2'd0;
        drink_valid_d = 1'b0;
`ifdef DRINK_ONEHOT_EN
        case (stable_q[7:4])
            4'b0001: begin drink_sel_d = 2'd0; drink_valid_d = 1'b1; end
            4'b0010: begin drink_sel_d = 2'd1; drink_valid_d = 1'b1; end
            4'b0100: begin drink_sel_d = 2'd2; drink_valid_d = 1'b1; end
            4'b1000: begin drink_sel_d = 2'd3; drink_valid_d = 1'b1; end
            default: begin drink_sel_d = 2'd0; drink_valid_d = 1'b0; end
        endcase
`else
        drink_valid_d = |stable_q[7:4];
        if (stable_q[4]) begin
            drink_sel_d = 2'd0;
        end else if (stable_q[5]) begin
            drink_sel_d = 2'd1;
        end else if (stable_q[6]) begin
            drink_sel_d = 2'd2;
        end else if (stable_q[7]) begin
            drink_sel_d = 2'd3;
        end
`endif
    end

    // State registers with synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_q         <= '0;
            sync2_q         <= '0;
            stable_q        <= '0;
            for (int i = 0; i < NumIn; i++) begin
                cnt_q[i] <= '0;
            end
            purchase_pend_q <= 1'b0;
            coin_pend_q     <= 3'd0;
            coin_overrun_q  <= 1'b0;
            drink_sel_q     <= 2'd0;
            drink_valid_q   <= 1'b0;
        end else begin
            sync1_q         <= raw;
            sync2_q         <= sync1_q;
            stable_q        <= stable_d;
            for (int i = 0; i < NumIn; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            purchase_pend_q <= purchase_pend_d;
            coin_pend_q     <= coin_pend_d;
            coin_overrun_q  <= coin_overrun_d;
            drink_sel_q     <= drink_sel_d;
            drink_valid_q   <= drink_valid_d;
        end
    end

    // Coin value follows the pending coin flags directly
    always_comb begin
        if (coin_pend_q[2]) begin
            coin_value = 8'd25;
        end else if (coin_pend_q[1]) begin
            coin_value = 8'd10;
        end else if (coin_pend_q[0]) begin
            coin_value = 8'd5;
        end else begin
            coin_value = 8'd0;
        end
    end

    assign purchase_o   = purchase_pend_q;
    assign nickel_o     = coin_pend_q[0];
    assign dime_o       = coin_pend_q[1];
    assign quarter_o    = coin_pend_q[2];
    assign coin_overrun = coin_overrun_q;
    assign drink_sel    = drink_sel_q;
    assign drink_valid  = drink_valid_q;

endmodule
